// File: rtl/tuning_ctrl.sv
// Encoder/preset tuning controller: conditions the quadrature encoder, keeps the
// tuned frequency within bounds, and publishes the matching DDS phase increment
// over a valid/ready stream. Encoder changes that arrive mid-transfer are merged,
// so the next transfer always carries the newest frequency.
module tuning_ctrl #(
    parameter int unsigned PHASE_W     = 27,
    parameter int unsigned F_MIN       = 100000,
    parameter int unsigned F_MAX       = 8000000,
    parameter int unsigned F_DEFAULT   = 1000000,
    parameter int unsigned STEP_FINE   = 100,
    parameter int unsigned STEP_COARSE = 10000,
    parameter int unsigned ACCEL_WIN   = 120000,
    parameter int unsigned DEBOUNCE    = 4800,
    parameter int unsigned PINC_MULT   = 8796093,
    parameter int unsigned PINC_SHIFT  = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               load_valid,
    input  logic [31:0]        load_freq,
    output logic [31:0]        freq_hz,
    output logic [PHASE_W-1:0] pinc_tdata,
    output logic               pinc_tvalid,
    input  logic               pinc_tready,
    output logic               busy
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);
    localparam int unsigned AC_W = $clog2(ACCEL_WIN + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SEND
    } state_t;

    state_t state, state_next;

    // Channel 0 is encoder A, channel 1 is encoder B.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      deb;
    logic            deb_a_d;
    logic [DB_W-1:0] db_cnt [2];
    logic            detent;

    logic [AC_W-1:0] accel_cnt;

    logic [32:0]     step;
    logic [32:0]     stepped;
    logic [31:0]     freq_stepped;
    logic [31:0]     load_clamped;
    logic [31:0]     freq_next;
    logic            freq_change;

    logic            pending;
    logic            pend_clear;
    logic            tvalid_next;
    logic            capture;
    logic [55:0]     prod;
    logic [PHASE_W-1:0] pinc_calc;

    assign raw = {enc_b, enc_a};

    // Two-flop synchroniser for the asynchronous encoder pins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb     <= '0;
            deb_a_d <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            deb_a_d <= deb[0];
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign detent = deb[0] & ~deb_a_d;

    // Cycles since the last detent, saturating at ACCEL_WIN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            accel_cnt <= AC_W'(ACCEL_WIN);
        end else if (detent) begin
            accel_cnt <= '0;
        end else if (accel_cnt != AC_W'(ACCEL_WIN)) begin
            accel_cnt <= accel_cnt + AC_W'(1);
        end
    end

    // Next frequency: load has priority over a detent; both are clamped to the band.
    always_comb begin
        step = (accel_cnt < AC_W'(ACCEL_WIN)) ? 33'(STEP_COARSE) : 33'(STEP_FINE);
        if (deb[1]) begin
            stepped = {1'b0, freq_hz} - step;
        end else begin
            stepped = {1'b0, freq_hz} + step;
        end
        // Bit 32 set means a down-step borrowed below zero or an up-step passed 2^32.
        if (stepped[32]) begin
            freq_stepped = deb[1] ? 32'(F_MIN) : 32'(F_MAX);
        end else if (stepped[31:0] < 32'(F_MIN)) begin
            freq_stepped = 32'(F_MIN);
        end else if (stepped[31:0] > 32'(F_MAX)) begin
            freq_stepped = 32'(F_MAX);
        end else begin
            freq_stepped = stepped[31:0];
        end

        if (load_freq < 32'(F_MIN)) begin
            load_clamped = 32'(F_MIN);
        end else if (load_freq > 32'(F_MAX)) begin
            load_clamped = 32'(F_MAX);
        end else begin
            load_clamped = load_freq;
        end

        freq_next = freq_hz;
        if (load_valid) begin
            freq_next = load_clamped;
        end else if (detent) begin
            freq_next = freq_stepped;
        end
        freq_change = (freq_next != freq_hz);
    end

    // Tuned frequency register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            freq_hz <= 32'(F_DEFAULT);
        end else begin
            freq_hz <= freq_next;
        end
    end

    // Pending flag: a new change wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending <= 1'b0;
        end else if (freq_change) begin
            pending <= 1'b1;
        end else if (pend_clear) begin
            pending <= 1'b0;
        end
    end

    // The product is formed combinationally in CALC and only the shifted result is
    // registered, so tvalid rises on the edge that leaves CALC.
    assign prod      = {24'd0, freq_hz} * 56'(PINC_MULT) + (56'd1 << (PINC_SHIFT - 1));
    assign pinc_calc = PHASE_W'(prod >> PINC_SHIFT);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= CALC;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state, pending clear and stream control.
    always_comb begin
        state_next  = state;
        pend_clear  = 1'b0;
        capture     = 1'b0;
        tvalid_next = pinc_tvalid;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next = CALC;
                    pend_clear = 1'b1;
                end
            end
            CALC: begin
                capture     = 1'b1;
                tvalid_next = 1'b1;
                state_next  = SEND;
            end
            SEND: begin
                if (pinc_tvalid && pinc_tready) begin
                    tvalid_next = 1'b0;
                    if (pending) begin
                        state_next = CALC;
                        pend_clear = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stream output registers; tdata only changes when leaving CALC.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pinc_tvalid <= 1'b0;
            pinc_tdata  <= '0;
        end else begin
            pinc_tvalid <= tvalid_next;
            if (capture) begin
                pinc_tdata <= pinc_calc;
            end
        end
    end

    assign busy = (state != IDLE) || pending;

endmodule

// File: tb/tb_tuning_ctrl.sv
// Self-checking bench for tuning_ctrl: a frequency model built from the
// behavioural rules, per-cycle stream/frequency checks, and directed scenarios
// with hand-computed expectations.
module tb_tuning_ctrl;

    localparam int unsigned AW   = 2000;
    localparam int unsigned DB   = 8;
    localparam int unsigned HOLD = 14;
    localparam longint      FMIN = 100000;
    localparam longint      FMAX = 8000000;
    localparam longint      FDEF = 1000000;
    localparam longint      SF   = 100;
    localparam longint      SC   = 10000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enc_a;
    logic        enc_b;
    logic        load_valid;
    logic [31:0] load_freq;
    logic [31:0] freq_hz;
    logic [26:0] pinc_tdata;
    logic        pinc_tvalid;
    logic        pinc_tready;
    logic        busy;

    always #5 clk = ~clk;

    tuning_ctrl #(.ACCEL_WIN(AW), .DEBOUNCE(DB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .load_valid (load_valid),
        .load_freq  (load_freq),
        .freq_hz    (freq_hz),
        .pinc_tdata (pinc_tdata),
        .pinc_tvalid(pinc_tvalid),
        .pinc_tready(pinc_tready),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    longint unsigned last_sent = 0;
    bit have_sent = 1'b0;

    // Model state
    bit     m_s1a, m_s2a, m_s1b, m_s2b;
    bit     m_last_a, m_last_b;
    int     m_run_a, m_run_b;
    bit     m_deb_a, m_deb_b, m_deb_a_prev;
    int     m_accel;
    longint m_freq = FDEF;

    function automatic longint unsigned pinc_of(input longint unsigned f);
        longint unsigned p;
        p = (f * 64'd8796093 + 64'd524288) >> 20;
        return p & 64'h7FF_FFFF;
    endfunction

    function automatic longint clamp_f(input longint v);
        if (v < FMIN) return FMIN;
        if (v > FMAX) return FMAX;
        return v;
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update and per-cycle comparison
    initial begin : monitor
        bit r, ea, eb, lv, rdy, detent, prev_tvalid;
        longint unsigned lf, prev_tdata;
        longint freq_old, stp;
        prev_tvalid = 1'b0;
        prev_tdata  = 0;
        forever begin
            @(posedge clk);
            r = reset_n; ea = enc_a; eb = enc_b; lv = load_valid; lf = load_freq; rdy = pinc_tready;
            #1;
            freq_old = m_freq;
            if (!r) begin
                m_s1a = 0; m_s2a = 0; m_s1b = 0; m_s2b = 0;
                m_last_a = 0; m_last_b = 0; m_run_a = 0; m_run_b = 0;
                m_deb_a = 0; m_deb_b = 0; m_deb_a_prev = 0;
                m_accel = AW;
                m_freq = FDEF;
                chk("rst_freq", freq_hz, FDEF);
                chk("rst_tvalid", pinc_tvalid, 0);
                chk("rst_tdata", pinc_tdata, 0);
                chk("rst_busy", busy, 1);
                prev_tvalid = 1'b0;
            end else begin
                detent = m_deb_a && !m_deb_a_prev;
                stp = SF;
                if (detent) begin
                    stp = (m_accel < AW) ? SC : SF;
                    m_accel = 0;
                end else if (m_accel < AW) begin
                    m_accel++;
                end
                if (lv) m_freq = clamp_f(longint'(lf));
                else if (detent) m_freq = clamp_f(m_deb_b ? m_freq - stp : m_freq + stp);
                m_deb_a_prev = m_deb_a;
                m_run_a = (m_s2a == m_last_a) ? m_run_a + 1 : 1;
                m_last_a = m_s2a;
                if (m_run_a >= DB) m_deb_a = m_s2a;
                m_run_b = (m_s2b == m_last_b) ? m_run_b + 1 : 1;
                m_last_b = m_s2b;
                if (m_run_b >= DB) m_deb_b = m_s2b;
                m_s2a = m_s1a; m_s1a = ea;
                m_s2b = m_s1b; m_s1b = eb;

                if (prev_tvalid && rdy) begin
                    xfers++;
                    last_sent = prev_tdata;
                    have_sent = 1'b1;
                    chk("tvalid_drop", pinc_tvalid, 0);
                end else if (prev_tvalid) begin
                    chk("hold_valid", pinc_tvalid, 1);
                    chk("hold_data", pinc_tdata, prev_tdata);
                end else if (pinc_tvalid) begin
                    chk("conv", pinc_tdata, pinc_of(longint'(freq_old)));
                end
                chk("freq", freq_hz, longint'(m_freq));
                if (pinc_tvalid) chk("busy_in_send", busy, 1);
                if (!busy && have_sent) chk("idle_published", last_sent, pinc_of(longint'(m_freq)));
                prev_tvalid = pinc_tvalid;
            end
            prev_tdata = pinc_tdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!pinc_tvalid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", pinc_tvalid, 1);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n = 0;
        while (xfers < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_xfers", xfers, target);
    endtask

    task automatic detent(input bit down);
        enc_b = down;
        tick(HOLD);
        enc_a = 1'b1;
        tick(HOLD);
        enc_a = 1'b0;
        tick(HOLD);
    endtask

    task automatic load(input longint unsigned f);
        load_freq  = 32'(f);
        load_valid = 1'b1;
        tick(1);
        load_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin : stimulus
        int x0, n;
        reset_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0;
        load_valid = 1'b0; load_freq = '0; pinc_tready = 1'b0;
        tick(3);
        chk("reset_freq_lit", freq_hz, 1000000);
        chk("reset_busy_lit", busy, 1);

        // Reset release publishes the default frequency once
        pinc_tready = 1'b1;
        reset_n = 1'b1;
        wait_xfers(1, 20);
        wait_idle(20);
        chk("default_pinc", last_sent, 8388608);

        // Single slow detent up; detent-to-tvalid latency
        tick(AW + 100);
        x0 = xfers;
        enc_b = 1'b0;
        enc_a = 1'b1;
        n = 0;
        while (freq_hz == 32'd1000000 && n < 60) begin @(negedge clk); n++; end
        chk("up_freq_lit", freq_hz, 1000100);
        n = 0;
        while (!pinc_tvalid && n < 10) begin @(negedge clk); n++; end
        chk("latency_freq_to_tvalid", n, 2);
        enc_a = 1'b0;
        tick(HOLD);
        wait_idle(40);
        chk("up_pinc_lit", last_sent, 8389447);
        chk("up_xfer_count", xfers - x0, 1);

        // Two detents down 1000 cycles apart: fine then coarse
        load(1000000);
        wait_idle(40);
        tick(AW + 100);
        detent(1'b1);
        chk("down1_freq", freq_hz, 999900);
        tick(1000 - 3 * HOLD);
        detent(1'b1);
        chk("down2_freq", freq_hz, 989900);
        wait_idle(40);

        // Edges on B alone
        x0 = xfers;
        enc_b = 1'b0; tick(HOLD);
        enc_b = 1'b1; tick(HOLD);
        enc_b = 1'b0; tick(HOLD);
        chk("b_only_freq", freq_hz, 989900);
        chk("b_only_xfers", xfers - x0, 0);

        // Load clamping to both bounds
        load(1000);
        tick(2);
        wait_idle(40);
        chk("load_min_freq", freq_hz, 100000);
        chk("load_min_pinc", last_sent, 838861);
        load(9000000);
        tick(2);
        wait_idle(40);
        chk("load_max_freq", freq_hz, 8000000);
        chk("load_max_pinc", last_sent, 67108864);

        // Detent up at F_MAX: no change, no transfer
        x0 = xfers;
        detent(1'b0);
        tick(HOLD);
        chk("fmax_freq", freq_hz, 8000000);
        chk("fmax_xfers", xfers - x0, 0);
        chk("fmax_busy", busy, 0);

        // Stalled sink with three detents during SEND
        tick(AW + 100);
        pinc_tready = 1'b0;
        x0 = xfers;
        load(2000000);
        wait_valid(10);
        chk("stall_first_data", pinc_tdata, 16777216);
        detent(1'b0);
        detent(1'b0);
        detent(1'b0);
        tick(10);
        chk("stall_valid", pinc_tvalid, 1);
        chk("stall_data", pinc_tdata, 16777216);
        chk("stall_freq", freq_hz, 2020100);
        pinc_tready = 1'b1;
        wait_xfers(x0 + 2, 20);
        wait_idle(20);
        tick(50);
        chk("coalesce_xfers", xfers - x0, 2);
        chk("coalesce_pinc", last_sent, 16945827);

        // Glitch shorter than the debounce window
        x0 = xfers;
        enc_a = 1'b1; tick(DB - 2);
        enc_a = 1'b0; tick(30);
        chk("glitch_freq", freq_hz, 2020100);
        chk("glitch_xfers", xfers - x0, 0);

        // Load in the same cycle as a detent: load wins
        enc_b = 1'b0;
        enc_a = 1'b1;
        n = 0;
        while (!m_deb_a && n < 30) begin @(negedge clk); n++; end
        chk("deb_a_seen", m_deb_a, 1);
        load_freq  = 32'd3000000;
        load_valid = 1'b1;
        tick(1);
        load_valid = 1'b0;
        tick(HOLD);
        enc_a = 1'b0;
        tick(HOLD);
        wait_idle(40);
        chk("load_vs_detent_freq", freq_hz, 3000000);
        chk("load_vs_detent_pinc", last_sent, 25165824);

        // Reset in the middle of SEND
        pinc_tready = 1'b0;
        load(5000000);
        wait_valid(10);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midsend_rst_tvalid", pinc_tvalid, 0);
        chk("midsend_rst_freq", freq_hz, 1000000);
        @(negedge clk);
        x0 = xfers;
        reset_n = 1'b1;
        pinc_tready = 1'b1;
        wait_xfers(x0 + 1, 20);
        wait_idle(20);
        chk("after_rst_pinc", last_sent, 8388608);
        chk("after_rst_freq", freq_hz, 1000000);

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
